// File: rtl/sensor_conditioner_if.sv
// Alarm front-end bundle: raw detector/ADC inputs in, clean registered alarm levels out.
interface sensor_conditioner_if;
    logic [7:0] smoke_data;
    logic       smoke_valid;
    logic       glp_raw;
    logic       fe_raw;
    logic       btn_apag_raw;
    logic       humoa;
    logic       humom;
    logic       glp;
    logic       fe;
    logic       apagsis;
    logic       sample_err;

    modport master (
        output smoke_data, smoke_valid, glp_raw, fe_raw, btn_apag_raw,
        input  humoa, humom, glp, fe, apagsis, sample_err
    );

    modport slave (
        input  smoke_data, smoke_valid, glp_raw, fe_raw, btn_apag_raw,
        output humoa, humom, glp, fe, apagsis, sample_err
    );
endinterface

// File: rtl/sensor_conditioner.sv
// Alarm input conditioning: sync + debounce of digital detectors, smoke level
// classification with hysteresis, and a sample-stream watchdog that fails safe to ALTO.
//
// state     | meaning
// ST_NORMAL | smoke below medium threshold
// ST_MEDIO  | medium smoke (humom)
// ST_ALTO   | high smoke (humoa), also forced when the sample stream stalls
module sensor_conditioner #(
    parameter int          DB_CYCLES = 16,
    parameter logic [7:0]  HUMO_MED  = 8'd80,
    parameter logic [7:0]  HUMO_ALTO = 8'd160,
    parameter logic [7:0]  HYST      = 8'd8,
    parameter int          TO_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    sensor_conditioner_if.slave   bus
);
    localparam int         DBW  = $clog2(DB_CYCLES + 1);
    localparam int         TOW  = $clog2(TO_CYCLES + 1);
    localparam logic [7:0] LO_M = HUMO_MED - HYST;
    localparam logic [7:0] LO_A = HUMO_ALTO - HYST;

    typedef enum logic [1:0] {ST_NORMAL, ST_MEDIO, ST_ALTO} state_t;

    // channel order: [0] glp, [1] fe, [2] button
    logic [2:0]           raw;
    logic [2:0]           sync1_q, sync1_d;
    logic [2:0]           sync2_q, sync2_d;
    logic [2:0]           level_q, level_d;
    logic [2:0][DBW-1:0]  db_cnt_q, db_cnt_d;
    logic                 btn_prev_q, btn_prev_d;
    logic                 apag_q, apag_d;
    state_t               state_q, state_d;
    logic [TOW-1:0]       to_cnt_q, to_cnt_d;
    logic                 err_q, err_d;

    assign raw = {bus.btn_apag_raw, bus.fe_raw, bus.glp_raw};

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        level_d    = level_q;
        db_cnt_d   = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DBW'(DB_CYCLES - 1))
                    level_d[i] = ~level_q[i];
                else
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
            end
        end
        btn_prev_d = level_q[2];
        apag_d     = apag_q ^ (level_q[2] & ~btn_prev_q);
    end

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        if (bus.smoke_valid) begin
            // A valid sample always beats expiry; while stalled state_q is already ALTO.
            to_cnt_d = '0;
            err_d    = 1'b0;
            case (state_q)
                ST_NORMAL: begin
                    if (bus.smoke_data >= HUMO_ALTO)     state_d = ST_ALTO;
                    else if (bus.smoke_data >= HUMO_MED) state_d = ST_MEDIO;
                end
                ST_MEDIO: begin
                    if (bus.smoke_data >= HUMO_ALTO)     state_d = ST_ALTO;
                    else if (bus.smoke_data < LO_M)      state_d = ST_NORMAL;
                end
                ST_ALTO: begin
                    if (bus.smoke_data < LO_M)           state_d = ST_NORMAL;
                    else if (bus.smoke_data < LO_A)      state_d = ST_MEDIO;
                end
                default: state_d = ST_NORMAL;
            endcase
        end else if (to_cnt_q != TOW'(TO_CYCLES)) begin
            to_cnt_d = to_cnt_q + TOW'(1);
            if (to_cnt_q == TOW'(TO_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = ST_ALTO;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            db_cnt_q   <= '0;
            btn_prev_q <= 1'b0;
            apag_q     <= 1'b0;
            state_q    <= ST_NORMAL;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            btn_prev_q <= btn_prev_d;
            apag_q     <= apag_d;
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.glp        = level_q[0];
    assign bus.fe         = level_q[1];
    assign bus.apagsis    = apag_q;
    assign bus.humom      = (state_q == ST_MEDIO);
    assign bus.humoa      = (state_q == ST_ALTO);
    assign bus.sample_err = err_q;
endmodule
